// File: rtl/pp_read_sched.sv
// ============================================================================
//  pp_read_sched : ping-pong BRAM read scheduler feeding matmul A operands.
//  Optional: define PP_RD_ERR_CHECK_EN to build the sticky protocol-error flag.
//  Rev 1.0
// ============================================================================
`default_nettype none

module pp_read_sched #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 4,
  parameter int W_ADDR_WIDTH = 4,
  parameter int INNER_BLOCKS = 2,
  parameter int ROW_PAIRS    = 2,
  parameter int COL_BLOCKS   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              bank_full,
  output logic [1:0]              bank_release,
  output logic [1:0]              rd_en,
  output logic [ADDR_WIDTH-1:0]   rd_addra,
  output logic [ADDR_WIDTH-1:0]   rd_addrb,
  input  logic [DATA_WIDTH-1:0]   bank0_douta,
  input  logic [DATA_WIDTH-1:0]   bank0_doutb,
  input  logic [DATA_WIDTH-1:0]   bank1_douta,
  input  logic [DATA_WIDTH-1:0]   bank1_doutb,
  output logic [DATA_WIDTH-1:0]   mat_a_even,
  output logic [DATA_WIDTH-1:0]   mat_a_odd,
  output logic [W_ADDR_WIDTH-1:0] w_addr,
  output logic                    mat_valid,
  input  logic                    mat_ready,
  input  logic                    systolic_finish,
  input  logic                    acc_done,
  output logic                    rd_bank,
  output logic                    busy,
  output logic                    err
);

  localparam int K_W = (INNER_BLOCKS > 1) ? $clog2(INNER_BLOCKS) : 1;
  localparam int C_W = (COL_BLOCKS > 1) ? $clog2(COL_BLOCKS) : 1;
  localparam int R_W = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(INNER_BLOCKS - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(COL_BLOCKS - 1);
  localparam logic [R_W-1:0] R_LAST = R_W'(ROW_PAIRS - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, LOAD, HOLD, WAIT_FIN, WAIT_ACC, RELEASE
  } state_t;

  state_t                  state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [C_W-1:0]          col_q, col_d;
  logic [R_W-1:0]          row_q, row_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [1:0]              rd_en_q, rd_en_d;
  logic [1:0]              bank_release_q, bank_release_d;
  logic                    mat_valid_q, mat_valid_d;
  logic [DATA_WIDTH-1:0]   mat_a_even_q, mat_a_even_d;
  logic [DATA_WIDTH-1:0]   mat_a_odd_q, mat_a_odd_d;
  logic [ADDR_WIDTH-1:0]   rd_addra_q, rd_addra_d;
  logic [ADDR_WIDTH-1:0]   rd_addrb_q, rd_addrb_d;
  logic [W_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic                    acc_done_q, acc_done_d;
  logic                    acc_rise;
  logic                    acc_event;

  assign acc_rise   = acc_done & ~acc_done_q;
  assign acc_done_d = acc_done;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    col_d          = col_q;
    row_d          = row_q;
    rd_bank_d      = rd_bank_q;
    rd_en_d        = 2'b00;
    bank_release_d = 2'b00;
    mat_valid_d    = mat_valid_q;
    mat_a_even_d   = mat_a_even_q;
    mat_a_odd_d    = mat_a_odd_q;
    rd_addra_d     = rd_addra_q;
    rd_addrb_d     = rd_addrb_q;
    w_addr_d       = w_addr_q;
    acc_event      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bank_full[rd_bank_q]) begin
          k_d     = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = LOAD;
      LOAD: begin
        mat_a_even_d = rd_bank_q ? bank1_douta : bank0_douta;
        mat_a_odd_d  = rd_bank_q ? bank1_doutb : bank0_doutb;
        mat_valid_d  = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (mat_ready) begin
          mat_valid_d = 1'b0;
          state_d     = WAIT_FIN;
        end
      end
      WAIT_FIN: begin
        if (systolic_finish) begin
          if (k_q != K_LAST) begin
            k_d     = k_q + K_W'(1);
            state_d = ISSUE;
          end else begin
            k_d = '0;
            // An accumulation rise landing with the last tile finish is consumed here.
            if (acc_rise) acc_event = 1'b1;
            else          state_d   = WAIT_ACC;
          end
        end
      end
      WAIT_ACC: begin
        if (acc_rise) acc_event = 1'b1;
      end
      RELEASE: begin
        rd_bank_d = ~rd_bank_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (acc_event) begin
      if ((row_q == R_LAST) && (col_q == C_LAST)) begin
        state_d = RELEASE;
      end else begin
        if (col_q == C_LAST) begin
          col_d = '0;
          row_d = row_q + R_W'(1);
        end else begin
          col_d = col_q + C_W'(1);
        end
        state_d = ISSUE;
      end
    end

    // Read strobe and addresses are registered so they line up with the ISSUE cycle.
    if (state_d == ISSUE) begin
      rd_en_d    = rd_bank_q ? 2'b10 : 2'b01;
      rd_addra_d = ADDR_WIDTH'(32'(k_d) + 32'(2 * INNER_BLOCKS) * 32'(row_d));
      rd_addrb_d = ADDR_WIDTH'(32'(k_d) + 32'(INNER_BLOCKS) * (32'(row_d) * 32'd2 + 32'd1));
      w_addr_d   = W_ADDR_WIDTH'(32'(k_d) + 32'(INNER_BLOCKS) * 32'(col_d));
    end
    if (state_d == RELEASE) begin
      bank_release_d = rd_bank_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      k_q            <= '0;
      col_q          <= '0;
      row_q          <= '0;
      rd_bank_q      <= 1'b0;
      rd_en_q        <= 2'b00;
      bank_release_q <= 2'b00;
      mat_valid_q    <= 1'b0;
      mat_a_even_q   <= '0;
      mat_a_odd_q    <= '0;
      rd_addra_q     <= '0;
      rd_addrb_q     <= '0;
      w_addr_q       <= '0;
      acc_done_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      col_q          <= col_d;
      row_q          <= row_d;
      rd_bank_q      <= rd_bank_d;
      rd_en_q        <= rd_en_d;
      bank_release_q <= bank_release_d;
      mat_valid_q    <= mat_valid_d;
      mat_a_even_q   <= mat_a_even_d;
      mat_a_odd_q    <= mat_a_odd_d;
      rd_addra_q     <= rd_addra_d;
      rd_addrb_q     <= rd_addrb_d;
      w_addr_q       <= w_addr_d;
      acc_done_q     <= acc_done_d;
    end
  end

`ifdef PP_RD_ERR_CHECK_EN
  logic err_q, err_d;
  logic acc_at_fin;

  assign acc_at_fin = (state_q == WAIT_FIN) && systolic_finish && (k_q == K_LAST);

  always_comb begin
    err_d = err_q;
    if (acc_rise && (state_q != WAIT_ACC) && !acc_at_fin) err_d = 1'b1;
    if ((state_q != IDLE) && !bank_full[rd_bank_q])       err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bank_release = bank_release_q;
  assign rd_en        = rd_en_q;
  assign rd_addra     = rd_addra_q;
  assign rd_addrb     = rd_addrb_q;
  assign mat_a_even   = mat_a_even_q;
  assign mat_a_odd    = mat_a_odd_q;
  assign w_addr       = w_addr_q;
  assign mat_valid    = mat_valid_q;
  assign rd_bank      = rd_bank_q;
  assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: doc/pp_read_sched.md
PP_READ_SCHED -- requirements
Module: pp_read_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 64, width of one BRAM word (one slice).
REQ-002 SHALL have parameter ADDR_WIDTH, 4, bank BRAM address width.
REQ-003 SHALL have parameter W_ADDR_WIDTH, 4, weight BRAM address width.
REQ-004 SHALL have parameter INNER_BLOCKS, 2, INNER_DIMENSION/BLOCK_SIZE, tiles per dot product.
REQ-005 SHALL have parameter ROW_PAIRS, 2, even/odd row pairs per bank.
REQ-006 SHALL have parameter COL_BLOCKS, 2, column blocks of matrix C.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port bank_full, input, 2, bit i high = bank i filled and readable.
REQ-010 SHALL have port bank_release, output, 2, one-cycle pulse when bank i is fully consumed.
REQ-011 SHALL have port rd_en, output, 2, read enable per bank.
REQ-012 SHALL have ports rd_addra / rd_addrb, output, ADDR_WIDTH each, even-row / odd-row read addresses, shared by both banks.
REQ-013 SHALL have ports bank0_douta, bank0_doutb, bank1_douta, bank1_doutb, input, DATA_WIDTH each, BRAM read data with 1-cycle latency.
REQ-014 SHALL have ports mat_a_even / mat_a_odd, output, DATA_WIDTH each, registered operands to matmul.
REQ-015 SHALL have port w_addr, output, W_ADDR_WIDTH, weight read address.
REQ-016 SHALL have port mat_valid, output, 1, operands valid; port mat_ready, input, 1, matmul accepts.
REQ-017 SHALL have ports systolic_finish and acc_done, input, 1 each, matmul tile-done and accumulation-done (level).
REQ-018 SHALL have ports rd_bank (output, 1, bank being read), busy (output, 1, state != IDLE), err (output, 1, sticky error).

Function
REQ-019 SHALL implement FSM IDLE, ISSUE, LOAD, HOLD, WAIT_FIN, WAIT_ACC, RELEASE; counters k (0..INNER_BLOCKS-1), col (0..COL_BLOCKS-1), row (0..ROW_PAIRS-1).
REQ-020 IDLE: when bank_full[rd_bank]=1, SHALL clear k/col/row and go to ISSUE; bank_full of the other bank SHALL be ignored.
REQ-021 ISSUE (1 cycle): rd_en[rd_bank]=1, rd_addra=k+INNER_BLOCKS*2*row, rd_addrb=k+INNER_BLOCKS*(2*row+1), w_addr=k+INNER_BLOCKS*col; next LOAD.
REQ-022 LOAD: SHALL register the rd_bank douta/doutb into mat_a_even/mat_a_odd, set mat_valid, go to HOLD.
REQ-023 HOLD: mat_valid and operands SHALL remain stable until mat_ready=1; on that cycle mat_valid clears and state goes to WAIT_FIN.
REQ-024 WAIT_FIN: on systolic_finish=1, if k<INNER_BLOCKS-1, k++ and go to ISSUE; otherwise k=0 and go to WAIT_ACC.
REQ-025 acc_done rising edge SHALL be detected with a registered copy; a rise coincident with the final systolic_finish in WAIT_FIN SHALL count as the WAIT_ACC event.
REQ-026 WAIT_ACC: on the acc_done rise, col++ (wrap to 0 with row++); if row=ROW_PAIRS-1 and col=COL_BLOCKS-1, go to RELEASE, else go to ISSUE.
REQ-027 RELEASE (1 cycle): bank_release[rd_bank]=1, rd_bank toggles, go to IDLE.
REQ-028 Address arithmetic SHALL be computed at full integer width and truncated to ADDR_WIDTH / W_ADDR_WIDTH.
REQ-029 Deassertion of bank_full mid-read SHALL NOT alter the sequence.

Reset
REQ-030 On rst, SHALL asynchronously set: state IDLE, all counters 0, rd_bank 0, rd_en 0, bank_release 0, mat_valid 0, mat_a_even/odd 0, rd_addra/b 0, w_addr 0, err 0, edge register 0.
REQ-031 Reset mid-operation SHALL abandon the current bank without issuing bank_release.

Configuration
REQ-032 With PP_RD_ERR_CHECK_EN defined, err SHALL set and hold until rst when either (a) an acc_done rise occurs outside WAIT_ACC and outside the REQ-025 case, or (b) bank_full[rd_bank] drops while busy; without the macro, err SHALL be constant 0 and no check logic is built.

Verification
REQ-033 Reset, then bank_full=01 with defaults -> ISSUE addra=0, addrb=2, w_addr=0; mat_valid rises 2 cycles after bank_full is seen.
REQ-034 mat_ready held 0 for 5 cycles -> mat_valid and operands stable for all 5 cycles; single handshake on release.
REQ-035 Full bank with defaults (8 finishes, 4 acc_done) -> address pairs (0,2),(1,3)x2 cols then (4,6),(5,7)x2 cols; bank_release=01 pulse; rd_bank=1.
REQ-036 acc_done rise in the same cycle as the final systolic_finish -> state skips waiting in WAIT_ACC; next ISSUE has col=1.
REQ-037 rst asserted during HOLD -> mat_valid=0 immediately (asynchronous); bank_release never pulses; rd_bank=0.
REQ-038 With PP_RD_ERR_CHECK_EN: stray acc_done rise in HOLD -> err=1 until rst; without the macro -> err stays 0.
